// File: rtl/key_pkg.sv
// Shared types and constants for the push-button debounce front end.
// Imported by key_debounce and by anything that talks to its outputs.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILTER0 = 2'd1,
    DOWN    = 2'd2,
    FILTER1 = 2'd3
  } key_fsm_e;

  // Key input is active-low: a closed contact pulls the line to ground.
  localparam logic KEY_PRESSED = 1'b0;

  // Stability window: 20 ms at 50 MHz for silicon, short window for simulation.
  localparam int unsigned CNT_MAX_SILICON = 1000000;
  localparam int unsigned CNT_MAX_SIM     = 5;

  // Registered output bundle of the debouncer.
  typedef struct packed {
    logic press;
    logic rls;
    logic level;
  } key_evt_t;

  localparam key_evt_t EVT_RESET = '{press: 1'b0, rls: 1'b0, level: ~KEY_PRESSED};

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// INIT sets the value both flops take during reset.
module sync_2ff #(
  parameter logic INIT = 1'b1
) (
  input  logic clock,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      meta <= INIT;
      q    <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounced push-button front end: synchronises an active-low key, filters
// bounce over CNT_MAX stable clocks and emits one-clock press/release pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_SILICON
) (
  input  logic clock,
  input  logic rst_n,
  input  logic key_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic key_state
);

  localparam int unsigned CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             key_s;
  key_fsm_e         state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  key_evt_t         evt, evt_n;

  sync_2ff #(
    .INIT (1'b1)
  ) u_sync (
    .clock (clock),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (key_s)
  );

  // State, stability counter and output registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      evt   <= EVT_RESET;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      evt   <= evt_n;
    end
  end

  // Next state, counter and output values; pulses default low every clock.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    evt_n     = evt;
    evt_n.press = 1'b0;
    evt_n.rls   = 1'b0;

    case (state)
      IDLE: begin
        if (key_s == KEY_PRESSED) begin
          state_n = FILTER0;
          cnt_n   = '0;
        end
      end

      FILTER0: begin
        if (key_s != KEY_PRESSED) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n     = DOWN;
          cnt_n       = '0;
          evt_n.press = 1'b1;
          evt_n.level = KEY_PRESSED;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      DOWN: begin
        if (key_s != KEY_PRESSED) begin
          state_n = FILTER1;
          cnt_n   = '0;
        end
      end

      FILTER1: begin
        if (key_s == KEY_PRESSED) begin
          state_n = DOWN;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n     = IDLE;
          cnt_n       = '0;
          evt_n.rls   = 1'b1;
          evt_n.level = ~KEY_PRESSED;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign press_pulse   = evt.press;
  assign release_pulse = evt.rls;
  assign key_state     = evt.level;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_MAX=5: per-clock vector table plus
// hand sequences for reset mid-filter and repeated press/release cycles.
module tb_key_debounce;
  import key_pkg::*;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic key_in = 1'b1;
  logic press_pulse, release_pulse, key_state;
  logic [3:0] q;

  int errors = 0;
  int checks = 0;

  always #10 clock = ~clock;

  key_debounce #(
    .CNT_MAX (CNT_MAX_SIM)
  ) dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .key_in        (key_in),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .key_state     (key_state)
  );

  // Downstream 4-bit counter whose cin is press_pulse.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) q <= 4'd0;
    else if (press_pulse) q <= q + 4'd1;
  end

  typedef struct packed {
    logic       rst;
    logic       key;
    logic       press;
    logic       rls;
    logic       state;
    logic [3:0] q;
  } vec_t;

  vec_t vec[$];

  task automatic add(input int n, input logic r, input logic k, input logic p,
                     input logic rl, input logic s, input logic [3:0] eq);
    vec_t v;
    v = '{rst: r, key: k, press: p, rls: rl, state: s, q: eq};
    for (int i = 0; i < n; i++) vec.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {1'b0, press_pulse, release_pulse, key_state, q};
  endfunction

  // One full press then release, checking pulse position and level every clock.
  task automatic press_release(input int n);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock) key_in = 1'b0;
      @(posedge clock) #1;
      chk($sformatf("cyc%0d_press", n), i, 8'({press_pulse, release_pulse, key_state}),
          8'({i == 7, 1'b0, i < 7}));
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clock) key_in = 1'b1;
      @(posedge clock) #1;
      chk($sformatf("cyc%0d_release", n), i, 8'({press_pulse, release_pulse, key_state}),
          8'({1'b0, i == 7, i >= 7}));
    end
  endtask

  initial begin
    // Reset held with key toggling.
    add(1, 0, 1, 0, 0, 1, 0); add(1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 1, 0); add(1, 0, 0, 0, 0, 1, 0);
    add(3, 1, 1, 0, 0, 1, 0);
    // Clean press held 20 clocks: pulse after E7, counter steps next edge.
    add(7, 1, 0, 0, 0, 1, 0); add(1, 1, 0, 1, 0, 0, 0); add(12, 1, 0, 0, 0, 0, 1);
    // Release held 12 clocks.
    add(7, 1, 1, 0, 0, 0, 1); add(1, 1, 1, 0, 1, 1, 1); add(4, 1, 1, 0, 0, 1, 1);
    // Bounce: low 3, high 1, low 2, high 4 -> nothing.
    add(3, 1, 0, 0, 0, 1, 1); add(1, 1, 1, 0, 0, 1, 1);
    add(2, 1, 0, 0, 0, 1, 1); add(4, 1, 1, 0, 0, 1, 1);
    // Settle low 15 clocks: pulse 7 edges after final fall is sampled.
    add(7, 1, 0, 0, 0, 1, 1); add(1, 1, 0, 1, 0, 0, 1); add(7, 1, 0, 0, 0, 0, 2);
    // Release back to idle.
    add(7, 1, 1, 0, 0, 0, 2); add(1, 1, 1, 0, 1, 1, 2); add(4, 1, 1, 0, 0, 1, 2);

    repeat (2) @(posedge clock);
    foreach (vec[i]) begin
      @(negedge clock);
      rst_n  = vec[i].rst;
      key_in = vec[i].key;
      @(posedge clock) #1;
      chk("vec", i, outs(),
          {1'b0, vec[i].press, vec[i].rls, vec[i].state, vec[i].q});
    end

    // Press reaches FILTER0 with cnt=2 (after E4), then reset with key held low.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock) key_in = 1'b0;
      @(posedge clock) #1;
      chk("mf_pre", i, 8'({press_pulse, release_pulse, key_state}), 8'b001);
    end
    @(negedge clock) rst_n = 1'b0;
    #1 chk("mf_rst", 0, outs(), 8'h10);
    for (int i = 1; i < 4; i++) begin
      @(posedge clock) #1;
      chk("mf_rst", i, outs(), 8'h10);
    end
    @(negedge clock) rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock) #1;
      chk("mf_press", i, 8'({press_pulse, release_pulse, key_state}),
          8'({i == 7, 1'b0, i < 7}));
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clock) key_in = 1'b1;
      @(posedge clock) #1;
      chk("mf_release", i, 8'({press_pulse, release_pulse, key_state}),
          8'({1'b0, i == 7, i >= 7}));
    end
    chk("mf_q", 0, 8'(q), 8'd1);

    for (int n = 0; n < 5; n++) press_release(n);
    @(posedge clock) #1;
    chk("q_final", 0, 8'(q), 8'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
